// File: rtl/i2s_slave_receiver.sv
// I2S slave receiver: synchronizes an externally mastered I2S bus into the
// clk domain, captures the first 16 bits of each channel slot MSB first and
// packs 16-bit or 8-bit samples into 32-bit words for a downstream sink.
// Optional overrun handling is enabled by defining I2S_RX_OVERRUN_EN, which
// adds writeFull, clearOverrun and a sticky overrun flag.
module i2s_slave_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sampleSize,
  input  logic        stereoMode,
  input  logic        record,
  input  logic        wclk,
  input  logic        bclk,
  input  logic        sdin,
`ifdef I2S_RX_OVERRUN_EN
  input  logic        writeFull,
  input  logic        clearOverrun,
  output logic        overrun,
`endif
  output logic [31:0] sampleData,
  output logic        writeReq
);

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STORE,
    WAIT
  } stateType;

  stateType state;

  logic [SYNC_STAGES-1:0] bclkSync;
  logic [SYNC_STAGES-1:0] wclkSync;
  logic [SYNC_STAGES-1:0] sdinSync;
  logic                   bclkPrev;
  logic                   wclkLast;

  logic        bclkS;
  logic        wclkS;
  logic        sdinS;
  logic        bclkRise;
  logic        wclkChange;
  logic        wclkFall;

  logic [3:0]  bitCnt;
  logic [2:0]  packCnt;
  logic [2:0]  packCntNext;
  logic [15:0] shiftReg;
  logic [31:0] packReg;
  logic [31:0] packNext;
  logic        channel;
  logic        keepSample;
  logic        wordDone;

  assign bclkS      = bclkSync[SYNC_STAGES-1];
  assign wclkS      = wclkSync[SYNC_STAGES-1];
  assign sdinS      = sdinSync[SYNC_STAGES-1];
  assign bclkRise   = bclkS & ~bclkPrev;
  assign wclkChange = bclkRise & (wclkS ^ wclkLast);
  assign wclkFall   = wclkChange & ~wclkS;
  assign keepSample = stereoMode | ~channel;

  // Bring the bus into the clk domain and remember wclk as seen at the last bclk rise
  always_ff @(posedge clk) begin
    if (reset) begin
      bclkSync <= '0;
      wclkSync <= '0;
      sdinSync <= '0;
      bclkPrev <= 1'b0;
      wclkLast <= 1'b0;
    end else begin
      bclkSync <= {bclkSync[SYNC_STAGES-2:0], bclk};
      wclkSync <= {wclkSync[SYNC_STAGES-2:0], wclk};
      sdinSync <= {sdinSync[SYNC_STAGES-2:0], sdin};
      bclkPrev <= bclkS;
      if (bclkRise) begin
        wclkLast <= wclkS;
      end
    end
  end

  // Work out where the captured sample lands in the pack register and whether it completes a word
  always_comb begin
    packNext    = packReg;
    packCntNext = packCnt + 3'd1;
    wordDone    = 1'b0;
    if (sampleSize) begin
      if (packCnt[0]) begin
        packNext[15:0] = shiftReg;
      end else begin
        packNext[31:16] = shiftReg;
      end
      wordDone = (packCntNext == 3'd2);
    end else begin
      case (packCnt[1:0])
        2'd0:    packNext[31:24] = shiftReg[15:8];
        2'd1:    packNext[23:16] = shiftReg[15:8];
        2'd2:    packNext[15:8]  = shiftReg[15:8];
        default: packNext[7:0]   = shiftReg[15:8];
      endcase
      wordDone = (packCntNext == 3'd4);
    end
  end

  // Capture state machine; the word request is registered so it appears the cycle after STORE
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bitCnt     <= 4'd0;
      packCnt    <= 3'd0;
      shiftReg   <= 16'd0;
      packReg    <= 32'd0;
      channel    <= 1'b0;
      sampleData <= 32'd0;
      writeReq   <= 1'b0;
`ifdef I2S_RX_OVERRUN_EN
      overrun    <= 1'b0;
`endif
    end else begin
      writeReq <= 1'b0;
`ifdef I2S_RX_OVERRUN_EN
      if (clearOverrun) begin
        overrun <= 1'b0;
      end
`endif
      case (state)
        IDLE: begin
          bitCnt   <= 4'd0;
          packCnt  <= 3'd0;
          shiftReg <= 16'd0;
          packReg  <= 32'd0;
          if (record && wclkFall) begin
            channel <= 1'b0;
            state   <= CAPTURE;
          end
        end

        CAPTURE: begin
          if (bclkRise) begin
            if (!record) begin
              bitCnt   <= 4'd0;
              shiftReg <= 16'd0;
              packCnt  <= 3'd0;
              packReg  <= 32'd0;
              state    <= IDLE;
            end else if (wclkChange) begin
              bitCnt   <= 4'd0;
              shiftReg <= 16'd0;
              channel  <= wclkS;
            end else begin
              shiftReg <= {shiftReg[14:0], sdinS};
              bitCnt   <= bitCnt + 4'd1;
              if (bitCnt == 4'd15) begin
                state <= STORE;
              end
            end
          end
        end

        STORE: begin
          if (keepSample) begin
            if (wordDone) begin
              packCnt <= 3'd0;
              packReg <= 32'd0;
`ifdef I2S_RX_OVERRUN_EN
              if (writeFull) begin
                overrun <= 1'b1;
              end else begin
                sampleData <= packNext;
                writeReq   <= 1'b1;
              end
`else
              sampleData <= packNext;
              writeReq   <= 1'b1;
`endif
            end else begin
              packCnt <= packCntNext;
              packReg <= packNext;
            end
          end
          state <= WAIT;
        end

        WAIT: begin
          if (bclkRise) begin
            if (!record) begin
              bitCnt   <= 4'd0;
              shiftReg <= 16'd0;
              packCnt  <= 3'd0;
              packReg  <= 32'd0;
              state    <= IDLE;
            end else if (wclkChange) begin
              bitCnt   <= 4'd0;
              shiftReg <= 16'd0;
              channel  <= wclkS;
              state    <= CAPTURE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2s_slave_receiver.sv
// Directed testbench for i2s_slave_receiver: drives an I2S master model with
// hand-built frames and checks the packed words against hand-computed values.
// Overrun scenarios are included when I2S_RX_OVERRUN_EN is defined.
module tb_i2s_slave_receiver;

  logic        clk;
  logic        reset;
  logic        sampleSize;
  logic        stereoMode;
  logic        record;
  logic        wclk;
  logic        bclk;
  logic        sdin;
  logic [31:0] sampleData;
  logic        writeReq;
`ifdef I2S_RX_OVERRUN_EN
  logic        writeFull;
  logic        clearOverrun;
  logic        overrun;
`endif

  int          total;
  int          bad;
  int          reqCount;
  int          pulseLen;
  int          maxPulse;
  logic [31:0] lastData;
  logic        curW;

  i2s_slave_receiver #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .sampleSize   (sampleSize),
    .stereoMode   (stereoMode),
    .record       (record),
    .wclk         (wclk),
    .bclk         (bclk),
    .sdin         (sdin),
`ifdef I2S_RX_OVERRUN_EN
    .writeFull    (writeFull),
    .clearOverrun (clearOverrun),
    .overrun      (overrun),
`endif
    .sampleData   (sampleData),
    .writeReq     (writeReq)
  );

  // 100 MHz system clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watch the sink interface on the falling clk edge and log each write request
  always @(negedge clk) begin
    if (reset) begin
      reqCount = 0;
      pulseLen = 0;
      maxPulse = 0;
      lastData = 32'd0;
    end else if (writeReq) begin
      reqCount = reqCount + 1;
      lastData = sampleData;
      pulseLen = pulseLen + 1;
    end else begin
      if (pulseLen > maxPulse) maxPulse = pulseLen;
      pulseLen = 0;
    end
  end

  // One bclk period (10 clk cycles); wclk and sdin change while bclk is low
  task automatic applyStimulus(input logic w, input logic d);
    wclk = w;
    sdin = d;
    bclk = 1'b0;
    #50;
    bclk = 1'b1;
    #50;
  endtask

  // One I2S channel slot: a delay bit, 16 data bits MSB first, then padding
  task automatic sendSlot(input logic w, input logic [15:0] data, input int nBits);
    applyStimulus(w, 1'b0);
    for (int i = 15; i >= 0; i--) applyStimulus(w, data[i]);
    for (int i = 0; i < nBits - 17; i++) applyStimulus(w, 1'b0);
    curW = w;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total = total + 1;
    assert (observed === expected)
    else begin
      bad = bad + 1;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Directed scenario sequence
  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    sampleSize = 1'b1;
    stereoMode = 1'b1;
    record     = 1'b0;
    wclk       = 1'b0;
    bclk       = 1'b0;
    sdin       = 1'b0;
    curW       = 1'b0;
`ifdef I2S_RX_OVERRUN_EN
    writeFull    = 1'b0;
    clearOverrun = 1'b0;
`endif
    #30;
    checkOutput("resetData", sampleData, 32'd0);
    checkOutput("resetReq", {31'd0, writeReq}, 32'd0);
`ifdef I2S_RX_OVERRUN_EN
    checkOutput("resetOverrun", {31'd0, overrun}, 32'd0);
`endif
    #10;
    reset = 1'b0;

    $display("[TB] stereo 16-bit, 32-bit frames");
    record = 1'b1;
    sendSlot(1'b1, 16'hDEAD, 32);
    sendSlot(1'b0, 16'h1234, 32);
    sendSlot(1'b1, 16'hABCD, 32);
    checkOutput("stereoCount", reqCount, 1);
    checkOutput("stereoData", lastData, 32'h1234ABCD);
    checkOutput("reqIdle", {31'd0, writeReq}, 32'd0);

    $display("[TB] mono 8-bit, 24-bit frames");
    record = 1'b0;
    applyStimulus(curW, 1'b0);
    sampleSize = 1'b0;
    stereoMode = 1'b0;
    record     = 1'b1;
    sendSlot(1'b0, 16'h11AA, 24);
    sendSlot(1'b1, 16'h9999, 24);
    sendSlot(1'b0, 16'h22BB, 24);
    sendSlot(1'b1, 16'h8888, 24);
    sendSlot(1'b0, 16'h33CC, 24);
    sendSlot(1'b1, 16'h7777, 24);
    checkOutput("monoPartial", reqCount, 1);
    sendSlot(1'b0, 16'h44DD, 24);
    checkOutput("monoCount", reqCount, 2);
    checkOutput("monoData", lastData, 32'h11223344);

    $display("[TB] early wclk toggle after 9 bits");
    record = 1'b0;
    applyStimulus(curW, 1'b0);
    sampleSize = 1'b1;
    stereoMode = 1'b1;
    record     = 1'b1;
    sendSlot(1'b1, 16'h7777, 32);
    applyStimulus(1'b0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1);
    sendSlot(1'b1, 16'h5A5A, 32);
    sendSlot(1'b0, 16'h0F0F, 32);
    checkOutput("toggleCount", reqCount, 3);
    checkOutput("toggleData", lastData, 32'h5A5A0F0F);

    $display("[TB] record dropped mid-pair");
    sendSlot(1'b1, 16'h1111, 32);
    record = 1'b0;
    sendSlot(1'b0, 16'h2222, 32);
    checkOutput("recordOffCount", reqCount, 3);
    record = 1'b1;
    sendSlot(1'b1, 16'h3333, 32);
    sendSlot(1'b0, 16'h4444, 32);
    checkOutput("reenableHalf", reqCount, 3);
    sendSlot(1'b1, 16'h5555, 32);
    checkOutput("reenableCount", reqCount, 4);
    checkOutput("reenableData", lastData, 32'h44445555);
    checkOutput("pulseWidth", maxPulse, 1);

`ifdef I2S_RX_OVERRUN_EN
    $display("[TB] overrun handling");
    writeFull = 1'b1;
    sendSlot(1'b0, 16'h6666, 32);
    sendSlot(1'b1, 16'h7777, 32);
    checkOutput("fullCount", reqCount, 4);
    checkOutput("fullOverrun", {31'd0, overrun}, 32'd1);
    checkOutput("fullDataHeld", sampleData, 32'h44445555);
    clearOverrun = 1'b1;
    applyStimulus(curW, 1'b0);
    checkOutput("clearOverrun", {31'd0, overrun}, 32'd0);
    sendSlot(1'b0, 16'h8888, 32);
    sendSlot(1'b1, 16'h9999, 32);
    checkOutput("setWins", {31'd0, overrun}, 32'd1);
    checkOutput("setWinsCount", reqCount, 4);
    clearOverrun = 1'b0;
    writeFull    = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_slave_receiver.md
I2S_SLAVE_RECEIVER -- requirements
Module: i2s_slave_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on bclk, wclk and sdin (min 2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port sampleSize  input  1  1 = 16-bit samples, 0 = 8-bit samples.
REQ-005 SHALL have port stereoMode  input  1  1 = keep both channels, 0 = keep left channel only.
REQ-006 SHALL have port record  input  1  capture enable.
REQ-007 SHALL have port wclk  input  1  I2S word clock from the external master (low = left channel).
REQ-008 SHALL have port bclk  input  1  I2S bit clock from the external master.
REQ-009 SHALL have port sdin  input  1  I2S serial data, MSB first.
REQ-010 SHALL have port sampleData  output  32  packed word; valid while writeReq is high and held until the next word.
REQ-011 SHALL have port writeReq  output  1  one-clk pulse requesting a sink write of sampleData.
REQ-012 SHALL have ports writeFull (input, 1, sink cannot accept), clearOverrun (input, 1) and overrun (output, 1, sticky drop flag), present only per REQ-031.

Function
REQ-013 SHALL pass bclk, wclk and sdin through SYNC_STAGES-flop synchronizers in the clk domain; clk SHALL be at least 8x the bclk frequency.
REQ-014 SHALL detect a bclk rising edge as synchronized bclk = 1 with its previous registered value = 0, and SHALL sample the synchronized wclk and sdin only on that edge.
REQ-015 SHALL flag a wclk change at a bclk rising edge when the sampled wclk differs from the value sampled at the previous bclk rising edge; a fall marks left, a rise marks right.
REQ-016 SHALL implement states IDLE, CAPTURE, STORE, WAIT.
REQ-017 IDLE: bit counter = 0, pack counter = 0, shift register = 0; SHALL go to CAPTURE when record = 1 and a wclk fall is flagged.
REQ-018 CAPTURE: at each bclk rise shift sdin into the LSB of a 16-bit shift register and increment the bit counter; after the 16th bit go to STORE.
REQ-019 CAPTURE: a wclk change flagged before 16 bits SHALL discard the partial sample, reset the bit counter and restart CAPTURE for the new channel; the bit on that same edge is not captured.
REQ-020 STORE (exactly one clk): if stereoMode = 1 or the channel is left, SHALL insert the sample into the pack register, then go to WAIT; a right-channel sample in mono mode SHALL be dropped with no state change.
REQ-021 16-bit packing: first sample into [31:16], second into [15:0]; word complete at pack count 2.
REQ-022 8-bit packing: sample[15:8] only; first to [31:24], then [23:16], [15:8], [7:0]; word complete at pack count 4.
REQ-023 On word completion SHALL load sampleData, pulse writeReq for one clk in the cycle after STORE, and reset the pack counter.
REQ-024 Bits after the 16th in a channel slot SHALL be ignored (32-bit and 24-bit frames supported).
REQ-025 WAIT: at bclk rise, if record = 0 go to IDLE; else if a wclk change is flagged go to CAPTURE (that edge carries no data bit); else stay.
REQ-026 record deasserted in CAPTURE SHALL take effect at the next bclk rise: partial sample and partial pack discarded, go to IDLE.
REQ-027 sampleSize and stereoMode SHALL be changed only in IDLE; behaviour otherwise is undefined.

Reset
REQ-028 On reset: state = IDLE, sampleData = 0, writeReq = 0, overrun = 0, all counters and the shift register = 0, synchronizer and edge registers = 0.
REQ-029 Reset SHALL take priority over every other input in the same clk.

Configuration
REQ-030 Macro I2S_RX_OVERRUN_EN SHALL select overrun handling.
REQ-031 Defined: writeFull, clearOverrun and overrun exist; on word completion with writeFull = 1 the word is dropped, writeReq stays 0 and overrun sets; clearOverrun = 1 clears it; a simultaneous set wins. Undefined: those ports are absent and writeReq is issued on every completed word.

Verification
REQ-032 Stereo, 16-bit, 32-bit frames, left = 0x1234, right = 0xABCD -> one writeReq with sampleData = 0x1234ABCD.
REQ-033 Mono, 8-bit, left samples 0x11xx, 0x22xx, 0x33xx, 0x44xx with rights interleaved -> one writeReq, sampleData = 0x11223344.
REQ-034 wclk toggles after 9 bits of left, then right = 0x5A5A, next left = 0x0F0F (stereo 16-bit) -> sampleData = 0x5A5A0F0F.
REQ-035 record dropped after the first of two samples, then raised again -> no writeReq until a fresh pair; the first word after re-enable holds only new samples.
REQ-036 With I2S_RX_OVERRUN_EN, writeFull = 1 at completion -> writeReq = 0, overrun = 1; clearOverrun with a simultaneous drop -> overrun stays 1.
